eq_ctrl: RTL

//  User-control FSM for the 6-band equalizer. Turns debounced key pulses into the

---
 rtl/eq_pkg.sv | 35 +++
 rtl/eq_gain_regfile.sv | 64 ++++++
 rtl/eq_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared types, constants and the gain clamp used by the equalizer control block.
package eq_pkg;

    localparam int NUM_BANDS  = 6;
    localparam int GAIN_MAX   = 12;
    localparam int GAIN_W     = 5;
    localparam int BAND_W     = 3;
    localparam int GAIN_OUT_W = 16;

    // Display mode codes; the numeric values are consumed directly by the decoder.
    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_TITLE = 3'd1,
        S_BAND  = 3'd2,
        S_GAIN  = 3'd3
    } eq_state_t;

    // Limits expressed at the widened (GAIN_W+1) arithmetic width.
    localparam logic signed [GAIN_W:0] SUM_HI = (GAIN_W + 1)'(GAIN_MAX);
    localparam logic signed [GAIN_W:0] SUM_LO = -SUM_HI;

    // Clamp a widened add/sub result back into -GAIN_MAX..+GAIN_MAX.
    function automatic logic signed [GAIN_W-1:0] clamp_gain(input logic signed [GAIN_W:0] v);
        logic signed [GAIN_W:0] c;
        if (v > SUM_HI) begin
            c = SUM_HI;
        end else if (v < SUM_LO) begin
            c = SUM_LO;
        end else begin
            c = v;
        end
        return c[GAIN_W-1:0];
    endfunction

endpackage

// File: rtl/eq_gain_regfile.sv
// Per-band signed gain storage with one saturating +/-1 write port, a global clear,
// and an asynchronous read of the band selected by i_idx (bands are 1-based).
module eq_gain_regfile
    import eq_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_we,
    input  logic                     i_dir_up,
    input  logic [BAND_W-1:0]        i_idx,
    output logic signed [GAIN_W-1:0] o_wr_gain,
    output logic                     o_changed,
    output logic signed [GAIN_W-1:0] o_nxt_gain
);

    localparam logic signed [GAIN_W:0] STEP_UP = (GAIN_W + 1)'(1);
    localparam logic signed [GAIN_W:0] STEP_DN = -STEP_UP;

    logic signed [GAIN_W-1:0] r_gain [NUM_BANDS];
    logic signed [GAIN_W-1:0] w_rd_gain;
    logic signed [GAIN_W:0]   w_sum;

    // Asynchronous read; index 0 (and anything out of range) reads as zero.
    always_comb begin
        w_rd_gain = '0;
        for (int i = 0; i < NUM_BANDS; i++) begin
            if (i_idx == BAND_W'(i + 1)) begin
                w_rd_gain = r_gain[i];
            end
        end
    end

    // Step in one extra bit so the +/-1 never wraps before clamping.
    always_comb begin
        w_sum      = {w_rd_gain[GAIN_W-1], w_rd_gain} + (i_dir_up ? STEP_UP : STEP_DN);
        o_wr_gain  = clamp_gain(w_sum);
        o_changed  = (o_wr_gain != w_rd_gain);
        o_nxt_gain = w_rd_gain;
        if (i_clr) begin
            o_nxt_gain = '0;
        end else if (i_we && o_changed) begin
            o_nxt_gain = o_wr_gain;
        end
    end

    // Register file update: clear wins, otherwise a write that actually moves the gain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                r_gain[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                if (i_clr) begin
                    r_gain[i] <= '0;
                end else if (i_we && o_changed && (i_idx == BAND_W'(i + 1))) begin
                    r_gain[i] <= o_wr_gain;
                end
            end
        end
    end

endmodule

// File: rtl/eq_ctrl.sv
// User-control FSM for the 6-band equalizer: key pulses -> display mode, selected
// band and per-band gain, plus a valid/ready update channel to the coefficient stage.
//
// Update channel: o_upd_valid rises with a payload (o_upd_band, o_upd_gain) and both
// stay frozen until a cycle where o_upd_valid & i_upd_ready; that is the transfer and
// valid falls on the following edge. Valid never falls without a transfer except on
// reset. o_upd_band == 0 means "all bands" (issued by a clear).
module eq_ctrl
    import eq_pkg::*;
#(
    parameter int TITLE_CYCLES = 50000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_key_next,
    input  logic                  i_key_up,
    input  logic                  i_key_down,
    input  logic                  i_key_clr,
    output logic [2:0]            o_state,
    output logic [BAND_W-1:0]     o_band,
    output logic [GAIN_OUT_W-1:0] o_gain,
    output logic                  o_upd_valid,
    output logic [BAND_W-1:0]     o_upd_band,
    output logic [GAIN_W-1:0]     o_upd_gain,
    input  logic                  i_upd_ready
);

    localparam int CNT_W = (TITLE_CYCLES > 2) ? $clog2(TITLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TITLE_CYCLES - 1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NUM_BANDS);

    eq_state_t                r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [BAND_W-1:0]        r_band;
    logic [GAIN_OUT_W-1:0]    r_gain_out;
    logic                     r_upd_valid;
    logic [BAND_W-1:0]        r_upd_band;
    logic [GAIN_W-1:0]        r_upd_gain;

    logic                     w_active;
    logic                     w_clr;
    logic                     w_next;
    logic                     w_up;
    logic                     w_down;
    logic                     w_gain_we;
    logic [BAND_W-1:0]        w_band_nxt;
    logic signed [GAIN_W-1:0] w_wr_gain;
    logic                     w_changed;
    logic signed [GAIN_W-1:0] w_nxt_gain;
    logic                     w_raise_gain;

    // Key decode with priority clr > next > up > down; nothing acts while disabled or OFF.
    always_comb begin
        w_active = i_enable && (r_state != S_OFF);
        w_clr    = w_active && i_key_clr;
        w_next   = w_active && !i_key_clr && i_key_next;
        w_up     = w_active && !i_key_clr && !i_key_next && i_key_up;
        w_down   = w_active && !i_key_clr && !i_key_next && !i_key_up && i_key_down;
    end

    // Band selection (BAND mode only) with wrap-around at both ends.
    always_comb begin
        w_band_nxt = r_band;
        if (r_state == S_BAND) begin
            if (w_up) begin
                w_band_nxt = (r_band == BAND_LAST) ? BAND_W'(1) : r_band + BAND_W'(1);
            end else if (w_down) begin
                w_band_nxt = (r_band == BAND_W'(1)) ? BAND_LAST : r_band - BAND_W'(1);
            end
        end
    end

    // Gain edits only in GAIN mode and only while the update channel is idle (no queueing).
    always_comb begin
        w_gain_we    = (r_state == S_GAIN) && (w_up || w_down) && !r_upd_valid;
        w_raise_gain = w_gain_we && w_changed;
    end

    // In GAIN mode the band cannot move, so indexing by the next band also addresses the write.
    eq_gain_regfile u_regfile (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_clr),
        .i_we       (w_gain_we),
        .i_dir_up   (w_up),
        .i_idx      (w_band_nxt),
        .o_wr_gain  (w_wr_gain),
        .o_changed  (w_changed),
        .o_nxt_gain (w_nxt_gain)
    );

    // Mode FSM, title timer, display registers and update handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_OFF;
            r_cnt       <= '0;
            r_band      <= BAND_W'(1);
            r_gain_out  <= '0;
            r_upd_valid <= 1'b0;
            r_upd_band  <= BAND_W'(1);
            r_upd_gain  <= '0;
        end else begin
            r_band     <= w_band_nxt;
            r_gain_out <= {{(GAIN_OUT_W - GAIN_W){w_nxt_gain[GAIN_W-1]}}, w_nxt_gain};

            if (r_upd_valid) begin
                if (i_upd_ready) begin
                    r_upd_valid <= 1'b0;
                end
            end else if (w_raise_gain) begin
                r_upd_valid <= 1'b1;
                r_upd_band  <= r_band;
                r_upd_gain  <= w_wr_gain;
            end else if (w_clr) begin
                r_upd_valid <= 1'b1;
                r_upd_band  <= '0;
                r_upd_gain  <= '0;
            end

            if (!i_enable) begin
                r_state <= S_OFF;
            end else begin
                case (r_state)
                    S_OFF: begin
                        r_state <= S_TITLE;
                        r_cnt   <= '0;
                    end
                    S_TITLE: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_next || (r_cnt == CNT_LAST)) begin
                            r_state <= S_BAND;
                        end
                    end
                    S_BAND: begin
                        if (w_next) begin
                            r_state <= S_GAIN;
                        end
                    end
                    S_GAIN: begin
                        if (w_next) begin
                            r_state <= S_BAND;
                        end
                    end
                    default: r_state <= S_OFF;
                endcase
            end
        end
    end

    assign o_state     = r_state;
    assign o_band      = r_band;
    assign o_gain      = r_gain_out;
    assign o_upd_valid = r_upd_valid;
    assign o_upd_band  = r_upd_band;
    assign o_upd_gain  = r_upd_gain;

endmodule
